bf_norm_div: RTL and testbench
==============================

# bf_norm_div

Normalising back end of the bilateral-filter datapath. It consumes the stream of per-tap weighted products (weight × intensity<<6, 28-bit) and the matching 14-bit combined weights for one 11×11 window. It accumulates both and divides the product sum by the weight sum with a serial restoring divider. It returns the filtered 8-bit pixel plus the 16-bit fixed-point quotient.

## Interface
Parameters:
- N_TAPS, 121, number of product/weight beats per window
- QW, 16, quotient width in bits (one divider iteration per bit)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- in_valid  input  1  product/weight beat valid
- in_ready  output  1  block can accept a beat
- in_prod  input  28  weighted product, unsigned, intensity carries 6 fractional bits
- in_wgt  input  14  weight for the same tap, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_pix  output  8  rounded, saturated filtered pixel
- out_q  output  16  raw quotient (pixel × 64, 6 fractional bits), saturated
- out_div0  output  1  weight sum was zero for this window

## Operation
- Registers:
  - acc_p is 35 bits: 28 bits plus ceil(log2 121) = 7.
  - acc_w is 21 bits.
  - tap_cnt is 7 bits.
  - bit_cnt is 4 bits.
  - rem is 22 bits.
  - quo is 16 bits.
- The FSM has three states: ACC, DIV, OUT.
- **ACC state**
  - in_ready = 1.
  - A beat is accepted when in_valid & in_ready. On acceptance: acc_p += in_prod, acc_w += in_wgt, tap_cnt++.
  - The beat accepted with tap_cnt == N_TAPS-1 is included in the sums. State then goes to DIV, with tap_cnt = 0 and bit_cnt = QW-1.
- **DIV state**
  - in_ready = 0.
  - Standard restoring long division of acc_p by acc_w, producing one quotient bit per cycle, MSB first. It always takes exactly QW cycles, so latency is fixed.
  - Overflow pre-check: acc_p[34:16] >= acc_w with acc_w != 0 means the quotient is ≥ 2^16. In that case the final quo is forced to 0xFFFF.
  - Divide-by-zero: acc_w == 0 forces quo = 0 and out_div0 = 1. The QW cycles are still spent.
  - After the bit_cnt == 0 iteration, state goes to OUT.
- **OUT state**
  - out_valid = 1. out_q = quo.
  - out_pix = min(255, (quo + 32) >> 6), computed at 17-bit width before the shift. This is round-half-up.
  - Outputs are held stable while out_ready = 0.
  - On out_valid & out_ready: acc_p, acc_w and quo clear, out_div0 clears, and state returns to ACC.
- There is no overlap between windows. in_ready stays low from the edge that accepts the last beat until the result handshake completes.

## Timing
- **Reset** (rst_n low at a rising edge):
  - State becomes ACC.
  - All accumulators and counters become 0.
  - out_valid = 0, out_pix = 0, out_q = 0, out_div0 = 0.
  - in_ready = 1 from the first edge with rst_n high.
  - Reset asserted mid-window, mid-DIV or in OUT discards all partial state. There is no residual output.
- **Input rate**: one beat per cycle. Gaps (in_valid low) are allowed in ACC and do not advance tap_cnt.
- **Latency**: let edge E accept the last beat.
  - DIV occupies the cycles after edges E+1 … E+QW.
  - out_valid rises after edge E+QW+1, i.e. 17 cycles after the last beat for QW = 16.
- **Throughput**: with out_ready held at 1, out_valid is high for exactly one cycle. The next window's first beat can be accepted on the cycle after the result handshake edge.
- in_valid asserted during DIV or OUT is ignored. The beat is not consumed because in_ready = 0.
- **Width rules**:
  - All arithmetic is unsigned.
  - Accumulators never wrap for N_TAPS ≤ 128.
  - out_q saturates at 0xFFFF and out_pix saturates at 255.

## Test plan
- **Uniform window**: 121 beats with in_wgt = 1, in_prod = 6400 (I = 100). Expected: acc_p = 774400, acc_w = 121, out_q = 6400, out_pix = 100, out_div0 = 0, out_valid 17 cycles after the last beat.
- **Rounding**: tap 0 w = 2, prod = 128; tap 1 w = 2, prod = 256; remaining 119 taps w = 0, prod = 0. Expected: out_q = 96, out_pix = 2 (1.5 rounds up).
- **Saturation**: 121 beats with in_wgt = 1, in_prod = 0xFFFFFFF. Expected: out_q = 0xFFFF, out_pix = 255. Also 121 beats with in_wgt = 16383, prod = 16383×16320. Expected: out_q = 16320, out_pix = 255.
- **Divide-by-zero**: all 121 weights 0 and products 0. Expected: out_div0 = 1, out_q = 0, out_pix = 0, same 17-cycle latency.
- **Backpressure and gaps**:
  - in_valid toggled 1/0 during the window; the result must equal the uniform case.
  - out_ready held low 5 cycles in OUT: out_* stay stable and in_ready stays 0.
  - in_valid held high through DIV/OUT: no beats are lost or double-counted in the next window.
- **Reset mid-operation**:
  - rst_n pulsed low for one cycle at tap 60. Expected: out_valid = 0 and in_ready = 1 next cycle, and a subsequent full uniform window gives out_pix = 100.
  - Repeat with the reset during DIV (bit_cnt = 7).

Source files
------------

// File: rtl/bf_norm_div.sv
// Normalising back end of the bilateral filter: accumulates one window of weighted products and
// weights, then divides them with a fixed-latency serial restoring divider.
module bf_norm_div #(
    parameter int unsigned N_TAPS = 121,
    parameter int unsigned QW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [27:0]   in_prod,
    input  logic [13:0]   in_wgt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_pix,
    output logic [QW-1:0] out_q,
    output logic          out_div0
);

    localparam int unsigned PW  = 28;
    localparam int unsigned CW  = $clog2(N_TAPS);
    localparam int unsigned APW = PW + CW;
    localparam int unsigned AWW = 21;
    localparam int unsigned BW  = $clog2(QW);
    localparam int unsigned RW  = AWW + 1;
    localparam int unsigned HW  = APW - QW;

    localparam logic [CW-1:0] TapLast = CW'(N_TAPS - 1);
    localparam logic [BW-1:0] BitLast = BW'(QW - 1);

    typedef enum logic [1:0] {StAcc, StDiv, StOut} state_e;

    state_e          state_q, state_d;
    logic [APW-1:0]  acc_p_q, acc_p_d;
    logic [AWW-1:0]  acc_w_q, acc_w_d;
    logic [CW-1:0]   tap_cnt_q, tap_cnt_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [QW-1:0]   quo_q, quo_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;
    logic            first_q, first_d;

    logic [RW-1:0]   rem_init;
    logic [RW-1:0]   divisor;
    logic [RW-1:0]   rem_sh;
    logic [RW-1:0]   rem_sub;
    logic            q_bit;
    logic [QW:0]     pix_sum;
    logic [QW:0]     pix_shift;

    // The upper dividend bits seed the remainder; if they already reach the divisor the quotient
    // cannot fit in QW bits.
    assign rem_init = {{(RW - HW){1'b0}}, acc_p_q[APW-1:QW]};
    assign divisor  = {1'b0, acc_w_q};
    assign rem_sh   = {rem_q[RW-2:0], acc_p_q[bit_cnt_q]};
    assign rem_sub  = rem_sh - divisor;
    assign q_bit    = (rem_sh >= divisor);

    assign pix_sum   = {1'b0, quo_q} + (QW + 1)'(32);
    assign pix_shift = pix_sum >> 6;

    always_comb begin
        state_d   = state_q;
        acc_p_d   = acc_p_q;
        acc_w_d   = acc_w_q;
        tap_cnt_d = tap_cnt_q;
        bit_cnt_d = bit_cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        first_d   = first_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StAcc: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_p_d = acc_p_q + APW'(in_prod);
                    acc_w_d = acc_w_q + AWW'(in_wgt);
                    if (tap_cnt_q == TapLast) begin
                        tap_cnt_d = '0;
                        bit_cnt_d = BitLast;
                        first_d   = 1'b1;
                        state_d   = StDiv;
                    end else begin
                        tap_cnt_d = tap_cnt_q + CW'(1);
                    end
                end
            end
            StDiv: begin
                // First DIV cycle only latches the operand checks and seeds the remainder.
                if (first_q) begin
                    first_d = 1'b0;
                    rem_d   = rem_init;
                    quo_d   = '0;
                    div0_d  = (acc_w_q == '0);
                    ovf_d   = (acc_w_q != '0) && (rem_init >= divisor);
                end else begin
                    rem_d     = q_bit ? rem_sub : rem_sh;
                    quo_d     = {quo_q[QW-2:0], q_bit};
                    bit_cnt_d = bit_cnt_q - BW'(1);
                    if (bit_cnt_q == '0) begin
                        state_d = StOut;
                        if (div0_q) begin
                            quo_d = '0;
                        end else if (ovf_q) begin
                            quo_d = '1;
                        end
                    end
                end
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_p_d = '0;
                    acc_w_d = '0;
                    rem_d   = '0;
                    quo_d   = '0;
                    div0_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = StAcc;
                end
            end
            default: state_d = StAcc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StAcc;
            acc_p_q   <= '0;
            acc_w_q   <= '0;
            tap_cnt_q <= '0;
            bit_cnt_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_p_q   <= acc_p_d;
            acc_w_q   <= acc_w_d;
            tap_cnt_q <= tap_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            first_q   <= first_d;
        end
    end

    always_comb begin
        out_q   = '0;
        out_pix = '0;
        if (state_q == StOut) begin
            out_q   = quo_q;
            out_pix = (pix_shift > (QW + 1)'(255)) ? 8'hFF : pix_shift[7:0];
        end
    end

    assign out_div0 = div0_q;

endmodule

// File: tb/tb_bf_norm_div.sv
// Directed bench for bf_norm_div: one task per scenario, hand-computed expectations.
module tb_bf_norm_div;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [27:0] in_prod;
    logic [13:0] in_wgt;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pix;
    logic [15:0] out_q;
    logic        out_div0;

    int n_pass;
    int n_total;

    bf_norm_div #(.N_TAPS(121), .QW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_wgt    (in_wgt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_q     (out_q),
        .out_div0  (out_div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_beat(input logic [27:0] p, input logic [13:0] w);
        in_valid = 1'b1;
        in_prod  = p;
        in_wgt   = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_uniform(input logic [27:0] p, input logic [13:0] w, input bit gaps);
        for (int i = 0; i < 121; i++) begin
            send_beat(p, w);
            if (gaps && i != 120) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Counts cycles from the last-beat edge until out_valid is seen (bounded).
    task automatic wait_result(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (out_q !== 16'd0 || out_pix !== 8'd0 || out_div0 !== 1'b0)
            $display("FAIL reset_outputs: got q=%0d pix=%0d div0=%b want 0/0/0",
                     out_q, out_pix, out_div0);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_uniform();
        int lat;
        send_uniform(28'd6400, 14'd1, 1'b0);
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL uniform_busy_ready: got %b want 0", in_ready);
        else n_pass++;
        wait_result(lat);
        n_total++;
        if (lat !== 17) $display("FAIL uniform_latency: got %0d want 17", lat);
        else n_pass++;
        n_total++;
        if (out_q !== 16'd6400 || out_pix !== 8'd100 || out_div0 !== 1'b0)
            $display("FAIL uniform_result: got q=%0d pix=%0d div0=%b want 6400/100/0",
                     out_q, out_pix, out_div0);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL uniform_one_cycle: got valid=%b ready=%b want 0/1",
                     out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_rounding();
        int lat;
        send_beat(28'd128, 14'd2);
        send_beat(28'd256, 14'd2);
        for (int i = 0; i < 119; i++) send_beat(28'd0, 14'd0);
        wait_result(lat);
        n_total++;
        if (out_q !== 16'd96 || out_pix !== 8'd2)
            $display("FAIL rounding: got q=%0d pix=%0d want 96/2", out_q, out_pix);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturation();
        int lat;
        send_uniform(28'hFFFFFFF, 14'd1, 1'b0);
        wait_result(lat);
        n_total++;
        if (out_q !== 16'hFFFF || out_pix !== 8'd255)
            $display("FAIL sat_overflow: got q=%0d pix=%0d want 65535/255", out_q, out_pix);
        else n_pass++;
        @(posedge clk);
        #1;
        send_uniform(28'd267370560, 14'd16383, 1'b0);
        wait_result(lat);
        n_total++;
        if (out_q !== 16'd16320 || out_pix !== 8'd255)
            $display("FAIL sat_pixel: got q=%0d pix=%0d want 16320/255", out_q, out_pix);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_div0();
        int lat;
        send_uniform(28'd0, 14'd0, 1'b0);
        wait_result(lat);
        n_total++;
        if (lat !== 17) $display("FAIL div0_latency: got %0d want 17", lat);
        else n_pass++;
        n_total++;
        if (out_div0 !== 1'b1 || out_q !== 16'd0 || out_pix !== 8'd0)
            $display("FAIL div0_result: got div0=%b q=%0d pix=%0d want 1/0/0",
                     out_div0, out_q, out_pix);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (out_div0 !== 1'b0) $display("FAIL div0_clear: got %b want 0", out_div0);
        else n_pass++;
    endtask

    task automatic test_gaps();
        int lat;
        send_uniform(28'd6400, 14'd1, 1'b1);
        wait_result(lat);
        n_total++;
        if (lat !== 17 || out_q !== 16'd6400 || out_pix !== 8'd100)
            $display("FAIL gaps: got lat=%0d q=%0d pix=%0d want 17/6400/100",
                     lat, out_q, out_pix);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0] q0;
        logic [7:0]  p0;
        out_ready = 1'b0;
        send_uniform(28'd3200, 14'd1, 1'b0);
        wait_result(lat);
        q0 = out_q;
        p0 = out_pix;
        n_total++;
        if (q0 !== 16'd3200 || p0 !== 8'd50)
            $display("FAIL bp_result: got q=%0d pix=%0d want 3200/50", q0, p0);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_q !== 16'd3200 ||
                out_pix !== 8'd50)
                $display("FAIL bp_hold%0d: got valid=%b ready=%b q=%0d pix=%0d want 1/0/3200/50",
                         i, out_valid, in_ready, out_q, out_pix);
            else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_valid_during_busy();
        int lat;
        send_uniform(28'd6400, 14'd1, 1'b0);
        in_valid = 1'b1;
        in_prod  = 28'd999;
        in_wgt   = 14'd7;
        wait_result(lat);
        n_total++;
        if (out_q !== 16'd6400) $display("FAIL busy_first: got q=%0d want 6400", out_q);
        else n_pass++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send_uniform(28'd6400, 14'd1, 1'b0);
        wait_result(lat);
        n_total++;
        if (lat !== 17 || out_q !== 16'd6400 || out_pix !== 8'd100)
            $display("FAIL busy_next: got lat=%0d q=%0d pix=%0d want 17/6400/100",
                     lat, out_q, out_pix);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_acc();
        int lat;
        for (int i = 0; i < 60; i++) send_beat(28'd100000, 14'd3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rst_acc_state: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        else n_pass++;
        send_uniform(28'd6400, 14'd1, 1'b0);
        wait_result(lat);
        n_total++;
        if (lat !== 17 || out_pix !== 8'd100 || out_q !== 16'd6400)
            $display("FAIL rst_acc_next: got lat=%0d q=%0d pix=%0d want 17/6400/100",
                     lat, out_q, out_pix);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_div();
        int lat;
        bit seen;
        send_uniform(28'd12800, 14'd1, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rst_div_state: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL rst_div_residual: got valid seen=%b want 0", seen);
        else n_pass++;
        send_uniform(28'd6400, 14'd1, 1'b0);
        wait_result(lat);
        n_total++;
        if (lat !== 17 || out_pix !== 8'd100 || out_q !== 16'd6400)
            $display("FAIL rst_div_next: got lat=%0d q=%0d pix=%0d want 17/6400/100",
                     lat, out_q, out_pix);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_wgt    = '0;
        out_ready = 1'b1;
        test_reset();
        test_uniform();
        test_rounding();
        test_saturation();
        test_div0();
        test_gaps();
        test_backpressure();
        test_valid_during_busy();
        test_reset_mid_acc();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
